// File: rtl/arm_pipe_pkg.sv
// Shared constants and types for the ARMv8 5-stage pipeline.
package arm_pipe_pkg;

  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/wb_data_sel.sv
// Write-back value select: ALU result, full 64-bit load, or zero-extended byte load.
module wb_data_sel
  import arm_pipe_pkg::*;
(
  input  logic  mem_to_reg,
  input  logic  ld_byte,
  input  word_t alu_result,
  input  word_t mem_data,
  output word_t sel
);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    sel = alu_result;
    if (mem_to_reg) begin
      if (ld_byte) sel = {{(DATA_W-8){1'b0}}, mem_data[7:0]};
      else         sel = mem_data;
    end
  end

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register driving the register-file write port from flops.
// Optional retire counter output enabled by defining MEM_WB_RETIRE_CNT_EN.
module mem_wb_pipe_reg
  import arm_pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic              in_ld_byte,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_data,
`ifdef MEM_WB_RETIRE_CNT_EN
  output logic [31:0]       retire_cnt,
`endif
  output logic              wb_valid,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  word_t    sel;
  logic     en;
  logic     valid_q;
  logic     en_q;
  reg_idx_t addr_q;
  word_t    data_q;

  wb_data_sel u_sel (
    .mem_to_reg (in_mem_to_reg),
    .ld_byte    (in_ld_byte),
    .alu_result (in_alu_result),
    .mem_data   (in_mem_data),
    .sel        (sel)
  );

  // XZR is architecturally read-as-zero, so a write to it must never reach the file.
  assign en = in_valid & in_reg_write & (in_rd != reg_idx_t'(ZERO_REG));

  // NOTE: flop state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      en_q    <= 1'b0;
    end else if (!stall) begin
      valid_q <= in_valid;
      en_q    <= en;
      addr_q  <= in_rd;
      data_q  <= sel;
    end
  end

  assign wb_valid = valid_q;
  assign wb_en    = en_q;
  assign wb_addr  = addr_q;
  assign wb_data  = data_q;

`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_q;

  // Counts instructions that actually enter WB; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset)                             retire_q <= '0;
    else if (!flush && !stall && in_valid) retire_q <= retire_q + 32'd1;
  end

  assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: driver queues hand-computed results, monitor compares.
module tb_mem_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        in_valid, in_reg_write, in_mem_to_reg, in_ld_byte;
  logic [4:0]  in_rd;
  logic [63:0] in_alu_result, in_mem_data;
  logic        wb_valid, wb_en;
  logic [4:0]  wb_addr;
  logic [63:0] wb_data;
`ifdef MEM_WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  typedef struct {
    int          idx;
    logic        valid;
    logic        en;
    logic [4:0]  addr;
    logic [63:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   vec_idx  = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_reg dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .in_ld_byte    (in_ld_byte),
    .in_rd         (in_rd),
    .in_alu_result (in_alu_result),
    .in_mem_data   (in_mem_data),
`ifdef MEM_WB_RETIRE_CNT_EN
    .retire_cnt    (retire_cnt),
`endif
    .wb_valid      (wb_valid),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data)
  );

  task automatic check(input string name, input int idx, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s vec %0d: got 0x%0h, expected 0x%0h", name, idx, act, req);
    end
  endtask

  // Apply one vector away from the clock edge and queue the outputs expected after the next edge.
  task automatic step(input logic rst, input logic st, input logic fl,
                      input logic v, input logic rw, input logic m2r, input logic lb,
                      input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] mem,
                      input logic ev, input logic een, input logic [4:0] ea, input logic [63:0] ed);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = st; flush = fl;
    in_valid = v; in_reg_write = rw; in_mem_to_reg = m2r; in_ld_byte = lb;
    in_rd = rd; in_alu_result = alu; in_mem_data = mem;
    e.idx = vec_idx; e.valid = ev; e.en = een; e.addr = ea; e.data = ed;
    sb_q.push_back(e);
    vec_idx++;
  endtask

  // Monitor: every stage output is a flop, so one expected entry per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("wb_valid", e.idx, {63'd0, wb_valid}, {63'd0, e.valid});
        check("wb_en",    e.idx, {63'd0, wb_en},    {63'd0, e.en});
        check("wb_addr",  e.idx, {59'd0, wb_addr},  {59'd0, e.addr});
        check("wb_data",  e.idx, wb_data,           e.data);
      end
    end
  end

  task automatic drain();
    int waited = 0;
    while (sb_q.size() != 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
  endtask

  initial begin
    //   rst st fl  v rw m2r lb  rd   alu                     mem                      ev en ea  ed
    step(1, 0, 0, 0, 0, 0, 0, 5'd0,  64'h0,                  64'h0,                   0, 0, 0,  64'h0);
    step(1, 0, 0, 1, 1, 0, 0, 5'd9,  64'h1111,               64'h2222,                0, 0, 0,  64'h0);
    step(0, 0, 0, 1, 1, 0, 0, 5'd3,  64'h1234,               64'hDEAD,                1, 1, 3,  64'h1234);
    step(0, 0, 0, 1, 1, 1, 1, 5'd7,  64'h55,                 64'hFFFF_FFFF_FFFF_FFA5, 1, 1, 7,  64'hA5);
    step(0, 0, 0, 1, 1, 1, 0, 5'd8,  64'h55,                 64'h0123_4567_89AB_CDEF, 1, 1, 8,  64'h0123_4567_89AB_CDEF);
    step(0, 0, 0, 1, 1, 0, 1, 5'd9,  64'hCAFE,               64'h11,                  1, 1, 9,  64'hCAFE);
    step(0, 0, 0, 1, 1, 0, 0, 5'd31, 64'h42,                 64'h0,                   1, 0, 31, 64'h42);
    step(0, 0, 0, 1, 0, 0, 0, 5'd4,  64'h99,                 64'h0,                   1, 0, 4,  64'h99);
    step(0, 0, 0, 0, 1, 0, 0, 5'd6,  64'h66,                 64'h0,                   0, 0, 6,  64'h66);
    step(0, 0, 0, 1, 1, 0, 0, 5'd5,  64'h77,                 64'h0,                   1, 1, 5,  64'h77);
    step(0, 1, 0, 1, 1, 0, 0, 5'd10, 64'hAAAA,               64'h0,                   1, 1, 5,  64'h77);
    step(0, 1, 0, 1, 1, 1, 0, 5'd10, 64'hAAAA,               64'hBBBB,                1, 1, 5,  64'h77);
    step(0, 1, 0, 0, 0, 0, 0, 5'd1,  64'h0,                  64'h0,                   1, 1, 5,  64'h77);
    step(0, 1, 1, 1, 1, 0, 0, 5'd11, 64'hBB,                 64'h0,                   0, 0, 5,  64'h77);
    step(0, 0, 0, 1, 1, 0, 0, 5'd12, 64'hC,                  64'h0,                   1, 1, 12, 64'hC);
    step(1, 1, 0, 1, 1, 0, 0, 5'd13, 64'hD,                  64'h0,                   0, 0, 0,  64'h0);
    step(0, 0, 0, 1, 1, 0, 0, 5'd2,  64'h9,                  64'h0,                   1, 1, 2,  64'h9);
    step(0, 0, 1, 1, 1, 0, 0, 5'd14, 64'hE,                  64'h0,                   0, 0, 2,  64'h9);
    step(0, 1, 0, 1, 1, 0, 0, 5'd15, 64'hF,                  64'h0,                   0, 0, 2,  64'h9);
    step(0, 0, 0, 1, 1, 1, 1, 5'd1,  64'h0,                  64'h1FF,                 1, 1, 1,  64'hFF);
    step(0, 0, 0, 1, 1, 0, 0, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  1, 1, 30, 64'hFFFF_FFFF_FFFF_FFFF);
    step(0, 0, 0, 1, 0, 1, 0, 5'd20, 64'h0,                  64'h8000_0000_0000_0001, 1, 0, 20, 64'h8000_0000_0000_0001);
    step(0, 1, 0, 1, 1, 0, 0, 5'd21, 64'h21,                 64'h0,                   1, 0, 20, 64'h8000_0000_0000_0001);
    step(0, 0, 1, 1, 1, 0, 0, 5'd22, 64'h22,                 64'h0,                   0, 0, 20, 64'h8000_0000_0000_0001);
    step(0, 0, 0, 0, 1, 0, 0, 5'd23, 64'h23,                 64'h0,                   0, 0, 23, 64'h23);
    drain();

`ifdef MEM_WB_RETIRE_CNT_EN
    // Valid captures since the last reset: rd 2, 1, 30, 20 -> 4.
    check("retire_cnt", vec_idx, {32'd0, retire_cnt}, 64'd4);
    @(negedge clk);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    step(0, 0, 0, 1, 1, 0, 0, 5'd24, 64'h24, 64'h0, 1, 1, 24, 64'h24);
    drain();
    check("retire_wrap", vec_idx, {32'd0, retire_cnt}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
